// File: rtl/dca_matrix_lsu_responder.sv
// -----------------------------------------------------------------------------
// dca_matrix_lsu_responder
//
// Turns one matrix LSU instruction {block_info, opcode} into a sequence of
// row requests (base address + row * stride), then counts row completions and
// returns a one-cycle inst_done credit once every row has been answered.
//
// Ports
//   clk          : single clock, rising edge
//   rstnn        : synchronous active-low reset
//   clear        : synchronous soft clear, same effect as reset
//   enable       : when low all state and counters hold, no requests issued
//   inst_valid   : instruction offered
//   inst_ready   : instruction can be accepted (IDLE & enable)
//   inst         : {block_info, opcode}
//   mreq_valid   : row request valid
//   mreq_ready   : row request accepted
//   mreq_write   : 1 = write row, 0 = read row
//   mreq_addr    : row base address
//   mrsp_valid   : one pulse per completed row
//   inst_done    : one-cycle pulse per completed instruction
//   busy         : FSM not in IDLE
//   opcode_err   : sticky illegal-opcode flag (only with the macro below)
//
// Configuration
//   DCA_MATRIX_LSU_RESPONDER_OPCODE_CHECK_EN
//     defined   : illegal opcodes set opcode_err, issue no rows, pulse inst_done
//     undefined : no opcode_err port; any opcode other than WRITE runs as READ
// -----------------------------------------------------------------------------

// Field layout of block_info and the LSU instruction word. Guarded so that a
// project-wide dca_matrix_info.vh, if already included, takes precedence.
`ifndef DCA_MATRIX_INFO_VH
`define DCA_MATRIX_INFO_VH
`define BW_DCA_MATRIX_INFO                 80
`define DCA_MATRIX_INFO_ADDRESS_RANGE      31:0
`define DCA_MATRIX_INFO_STRIDE_SIZE_RANGE  63:32
`define DCA_MATRIX_INFO_NUM_ROW_RANGE      79:64
`endif

`ifndef DCA_MATRIX_LSU_INST_VH
`define DCA_MATRIX_LSU_INST_VH
`define BW_DCA_MATRIX_LSU_INST_OPCODE      2
`define BW_DCA_MATRIX_LSU_INST             82
`define DCA_MATRIX_LSU_INST_OPCODE_READ    2'd1
`define DCA_MATRIX_LSU_INST_OPCODE_WRITE   2'd2
`endif

module dca_matrix_lsu_responder #(
    parameter int unsigned MATRIX_SIZE_PARA = 8
) (
    input  logic                               clk,
    input  logic                               rstnn,
    input  logic                               clear,
    input  logic                               enable,
    input  logic                               inst_valid,
    output logic                               inst_ready,
    input  logic [`BW_DCA_MATRIX_LSU_INST-1:0] inst,
    output logic                               mreq_valid,
    input  logic                               mreq_ready,
    output logic                               mreq_write,
    output logic [31:0]                        mreq_addr,
    input  logic                               mrsp_valid,
    output logic                               inst_done,
    output logic                               busy
`ifdef DCA_MATRIX_LSU_RESPONDER_OPCODE_CHECK_EN
    ,
    output logic                               opcode_err
`endif
);

    localparam int unsigned CNT_W = MATRIX_SIZE_PARA + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [`BW_DCA_MATRIX_INFO-1:0]           w_block_info;
    logic [`BW_DCA_MATRIX_LSU_INST_OPCODE-1:0] w_opcode;
    logic [31:0]                              w_inst_addr;
    logic [31:0]                              w_inst_stride;
    logic [CNT_W-1:0]                         w_inst_num_row;
    logic                                     w_opcode_legal;

    assign w_block_info   = inst[`BW_DCA_MATRIX_LSU_INST-1:`BW_DCA_MATRIX_LSU_INST_OPCODE];
    assign w_opcode       = inst[`BW_DCA_MATRIX_LSU_INST_OPCODE-1:0];
    assign w_inst_addr    = w_block_info[`DCA_MATRIX_INFO_ADDRESS_RANGE];
    assign w_inst_stride  = w_block_info[`DCA_MATRIX_INFO_STRIDE_SIZE_RANGE];
    assign w_inst_num_row = CNT_W'(w_block_info[`DCA_MATRIX_INFO_NUM_ROW_RANGE]);

`ifdef DCA_MATRIX_LSU_RESPONDER_OPCODE_CHECK_EN
    assign w_opcode_legal = (w_opcode == `DCA_MATRIX_LSU_INST_OPCODE_READ) |
                            (w_opcode == `DCA_MATRIX_LSU_INST_OPCODE_WRITE);
`else
    assign w_opcode_legal = 1'b1;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]                                r_state;
    logic [31:0]                               r_addr;
    logic [31:0]                               r_stride;
    logic [CNT_W-1:0]                          r_num_row;
    logic [`BW_DCA_MATRIX_LSU_INST_OPCODE-1:0] r_opcode;
    logic [CNT_W-1:0]                          r_issue_cnt;
    logic [CNT_W-1:0]                          r_rsp_cnt;
    logic                                      r_done;

    logic [1:0]                                w_state_nxt;
    logic [31:0]                               w_addr_nxt;
    logic [31:0]                               w_stride_nxt;
    logic [CNT_W-1:0]                          w_num_row_nxt;
    logic [`BW_DCA_MATRIX_LSU_INST_OPCODE-1:0] w_opcode_nxt;
    logic [CNT_W-1:0]                          w_issue_cnt_nxt;
    logic [CNT_W-1:0]                          w_rsp_cnt_nxt;
    logic                                      w_done_nxt;
    logic                                      w_err_set;

    // ------------------------------------------------------------------
    // Handshakes and datapath
    // ------------------------------------------------------------------
    logic        w_live;
    logic        w_accept;
    logic        w_req_hs;
    logic        w_rsp;
    logic [CNT_W-1:0] w_rsp_cnt_inc;
    logic        w_last_issue;
    logic        w_all_rsp;
    logic [31:0] w_issue_cnt_ext;

    // Gate handshake outputs with reset/clear so nothing looks accepted in a
    // cycle that is about to be wiped.
    assign w_live     = rstnn & ~clear;
    assign inst_ready = (r_state == ST_IDLE) & enable & w_live;
    assign mreq_valid = (r_state == ST_ISSUE) & enable & w_live;

    assign w_accept   = inst_valid & inst_ready;
    assign w_req_hs   = mreq_valid & mreq_ready;
    // Responses only count while an instruction is in flight.
    assign w_rsp      = mrsp_valid & (r_state != ST_IDLE) & enable;

    assign w_rsp_cnt_inc = r_rsp_cnt + CNT_W'(w_rsp);
    assign w_last_issue  = (r_issue_cnt == (r_num_row - CNT_W'(1)));
    assign w_all_rsp     = (w_rsp_cnt_inc == r_num_row);

    assign w_issue_cnt_ext = 32'(r_issue_cnt);
    assign mreq_addr       = r_addr + (w_issue_cnt_ext * r_stride);
    assign mreq_write      = (r_opcode == `DCA_MATRIX_LSU_INST_OPCODE_WRITE);

    assign inst_done = r_done;
    assign busy      = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_stride_nxt    = r_stride;
        w_num_row_nxt   = r_num_row;
        w_opcode_nxt    = r_opcode;
        w_issue_cnt_nxt = r_issue_cnt;
        w_rsp_cnt_nxt   = r_rsp_cnt;
        // inst_done is a credit pulse: it drops after one cycle even while
        // enable is low, so a stall cannot duplicate the credit.
        w_done_nxt      = 1'b0;
        w_err_set       = 1'b0;

        if (enable) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_addr_nxt      = w_inst_addr;
                        w_stride_nxt    = w_inst_stride;
                        w_num_row_nxt   = w_inst_num_row;
                        w_opcode_nxt    = w_opcode;
                        w_issue_cnt_nxt = '0;
                        w_rsp_cnt_nxt   = '0;
                        if (!w_opcode_legal) begin
                            w_err_set  = 1'b1;
                            w_done_nxt = 1'b1;
                        end else if (w_inst_num_row == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    w_rsp_cnt_nxt = w_rsp_cnt_inc;
                    if (w_req_hs) begin
                        w_issue_cnt_nxt = r_issue_cnt + CNT_W'(1);
                        if (w_last_issue) begin
                            // Responses may already have caught up with the
                            // last request; skip DRAIN in that case.
                            if (w_all_rsp) begin
                                w_state_nxt = ST_IDLE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = ST_DRAIN;
                            end
                        end
                    end
                end

                ST_DRAIN: begin
                    w_rsp_cnt_nxt = w_rsp_cnt_inc;
                    if (w_all_rsp) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_stride    <= '0;
            r_num_row   <= '0;
            r_opcode    <= '0;
            r_issue_cnt <= '0;
            r_rsp_cnt   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_stride    <= w_stride_nxt;
            r_num_row   <= w_num_row_nxt;
            r_opcode    <= w_opcode_nxt;
            r_issue_cnt <= w_issue_cnt_nxt;
            r_rsp_cnt   <= w_rsp_cnt_nxt;
            r_done      <= w_done_nxt;
        end
    end

`ifdef DCA_MATRIX_LSU_RESPONDER_OPCODE_CHECK_EN
    logic r_opcode_err;

    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            r_opcode_err <= 1'b0;
        end else if (w_err_set) begin
            r_opcode_err <= 1'b1;
        end
    end

    assign opcode_err = r_opcode_err;
`else
    // Without opcode checking every opcode is executable.
    logic w_unused_err_set;
    assign w_unused_err_set = w_err_set;
`endif

endmodule
